// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: bus widths, the
// responder FSM state encoding and the word-index helper.
package rv_mem_pkg;

    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam int BYTE_W   = 8;
    // Byte-address bit where the word index starts (32-bit words).
    localparam int WORD_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of word-index bits for a RAM of the given depth.
    function automatic int word_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// DEPTH x 32-bit storage with four byte-lane write enables and a
// registered (synchronous) read port. Contents are not reset.
module dmem_ram_bank
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write: only lanes with their strobe set are updated.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int lane = 0; lane < STRB_W; lane++) begin
                if (wr_strb[lane]) begin
                    mem[idx][lane*BYTE_W +: BYTE_W] <= wdata[lane*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read register only moves when a read is requested, so it holds the
    // loaded word for as long as the response is pending.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the processor data port. Accepts one
// request at a time, waits WAIT_CYC cycles, performs the RAM access on
// the edge that enters RESP and holds the response until it is taken.
// Optional feature macro: DMEM_ERR_EN -- when defined, misaligned or
// out-of-range addresses return rsp_err=1 without touching the RAM;
// when undefined, addresses wrap modulo 4*DEPTH and rsp_err is 0.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W     = word_idx_w(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic                ready_q;
    logic                accept;
    logic                enter_resp;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [STRB_W-1:0]   lat_wstrb;

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [STRB_W-1:0]   acc_wstrb;
    logic                acc_err;

    logic                err_q;
    logic                load_q;
    logic [DATA_W-1:0]   ram_rdata;

    // Next-state and counter logic. With zero wait states the accepting
    // edge is also the edge that enters RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && ready_q) begin
                    accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                    cnt_next   = 4'd0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The access uses the live request when entering RESP straight from
    // IDLE, otherwise the copy latched at acceptance.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_wstrb = lat_wstrb;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
    end

`ifdef DMEM_ERR_EN
    // Fault on misaligned addresses or any byte address past the RAM.
    always_comb begin
        acc_err = 1'b0;
        if ((acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_W-1:IDX_W+WORD_LSB] != '0)) begin
            acc_err = 1'b1;
        end
    end
`else
    // Addresses wrap; low byte bits and bits above the index are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[ADDR_W-1:IDX_W+WORD_LSB], acc_addr[1:0]};

    always_comb begin
        acc_err = 1'b0;
    end
`endif

    // State, counter and handshake registers. req_ready is registered so
    // it only rises on the first edge after reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_q <= (state_next == IDLE);
        end
    end

    // Capture the request fields on acceptance so later bus activity is ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    // Response status: decided on the edge entering RESP, cleared on exit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end else if (enter_resp) begin
            err_q  <= acc_err;
            load_q <= !acc_we && !acc_err;
        end else if (state == RESP && rsp_ready) begin
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end
    end

    dmem_ram_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (enter_resp && acc_we && !acc_err),
        .wr_strb (acc_wstrb),
        .rd_en   (enter_resp && !acc_we && !acc_err),
        .idx     (acc_addr[IDX_W+WORD_LSB-1:WORD_LSB]),
        .wdata   (acc_wdata),
        .rdata   (ram_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = (state == RESP && load_q) ? ram_rdata : '0;

`ifdef DMEM_ERR_EN
    assign rsp_err = (state == RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with 0, 1 and 3
// wait states share clock and reset; a word-array model predicts every
// response. Honours DMEM_ERR_EN when it is defined for the build.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int N     = 3;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wstrb [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    logic [31:0] model_mem [N][DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH    (DEPTH),
            .ADDR_W   (32),
            .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
    endfunction

    function automatic bit addr_faults(input logic [31:0] addr);
`ifdef DMEM_ERR_EN
        return (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
`else
        return (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_reset(input int sel);
        check_output($sformatf("rst_req_ready%0d", sel), {31'b0, req_ready[sel]}, 32'd0);
        check_output($sformatf("rst_rsp_valid%0d", sel), {31'b0, rsp_valid[sel]}, 32'd0);
        check_output($sformatf("rst_rsp_rdata%0d", sel), rsp_rdata[sel], 32'd0);
        check_output($sformatf("rst_rsp_err%0d", sel), {31'b0, rsp_err[sel]}, 32'd0);
    endtask

    // One full transaction with optional response backpressure.
    task automatic apply_stimulus(input int sel, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb, input int stall);
        int          n;
        int          lat;
        int          idx;
        bit          exp_err;
        logic [31:0] exp_rdata;
        string       id;

        id        = $sformatf("s%0d_%s_%h", sel, we ? "st" : "ld", addr);
        exp_err   = addr_faults(addr);
        idx       = int'((addr >> 2) % DEPTH);
        exp_rdata = (!we && !exp_err) ? model_mem[sel][idx] : 32'd0;

        @(negedge clock);
        req_valid[sel] = 1'b1;
        req_we[sel]    = we;
        req_addr[sel]  = addr;
        req_wdata[sel] = wdata;
        req_wstrb[sel] = wstrb;
        n = 0;
        while (req_ready[sel] !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check_output({id, "_req_ready_timeout"}, 32'd0, 32'd1);

        @(negedge clock);
        lat = 1;
        while (rsp_valid[sel] !== 1'b1 && lat < 30) begin
            check_output({id, "_ready_in_wait"}, {31'b0, req_ready[sel]}, 32'd0);
            req_addr[sel]  = $urandom;
            req_wdata[sel] = $urandom;
            req_we[sel]    = 1'($urandom);
            req_wstrb[sel] = 4'($urandom);
            @(negedge clock);
            lat++;
        end
        req_valid[sel] = 1'b0;

        check_output({id, "_latency"}, 32'(lat), 32'(wait_of(sel) + 1));
        check_output({id, "_rdata"}, rsp_rdata[sel], exp_rdata);
        check_output({id, "_err"}, {31'b0, rsp_err[sel]}, {31'b0, exp_err});
        check_output({id, "_ready_in_resp"}, {31'b0, req_ready[sel]}, 32'd0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            check_output({id, "_stall_valid"}, {31'b0, rsp_valid[sel]}, 32'd1);
            check_output({id, "_stall_rdata"}, rsp_rdata[sel], exp_rdata);
            check_output({id, "_stall_ready"}, {31'b0, req_ready[sel]}, 32'd0);
        end

        rsp_ready[sel] = 1'b1;
        @(negedge clock);
        rsp_ready[sel] = 1'b0;
        check_output({id, "_done_valid"}, {31'b0, rsp_valid[sel]}, 32'd0);
        check_output({id, "_done_rdata"}, rsp_rdata[sel], 32'd0);
        check_output({id, "_done_err"}, {31'b0, rsp_err[sel]}, 32'd0);
        check_output({id, "_done_ready"}, {31'b0, req_ready[sel]}, 32'd1);

        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) model_mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    // Random address near the initialised low words, with alias/fault variants.
    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        int          kind;
        base = 32'($urandom_range(0, 31)) * 32'd4;
        kind = $urandom_range(0, 5);
        case (kind)
            0:       return base + 32'h400 * 32'($urandom_range(1, 3));
            1:       return base + 32'($urandom_range(1, 3));
            2:       return base + 32'h8000_0000;
            default: return base;
        endcase
    endfunction

    initial begin
        for (int s = 0; s < N; s++) begin
            req_valid[s] = 1'b0;
            req_we[s]    = 1'b0;
            req_addr[s]  = '0;
            req_wdata[s] = '0;
            req_wstrb[s] = '0;
            rsp_ready[s] = 1'b0;
            for (int w = 0; w < DEPTH; w++) model_mem[s][w] = '0;
        end

        repeat (3) @(negedge clock);
        for (int s = 0; s < N; s++) check_idle_reset(s);
        reset_n = 1'b1;
        #1;
        for (int s = 0; s < N; s++)
            check_output($sformatf("ready_before_edge%0d", s), {31'b0, req_ready[s]}, 32'd0);
        @(posedge clock);
        #1;
        for (int s = 0; s < N; s++)
            check_output($sformatf("ready_after_edge%0d", s), {31'b0, req_ready[s]}, 32'd1);

        apply_stimulus(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        apply_stimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        apply_stimulus(1, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 0);
        apply_stimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        check_output("partial_store_word", model_mem[1][4], 32'hDEAD_BEAA);

        apply_stimulus(0, 1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, 0);
        apply_stimulus(2, 1'b1, 32'h14, 32'h0BAD_CAFE, 4'hF, 0);

        for (int s = 0; s < N; s++) begin
            for (int w = 0; w < 32; w++) begin
                apply_stimulus(s, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
            end
        end

        for (int s = 0; s < N; s++) begin
            apply_stimulus(s, 1'b0, 32'h12, 32'h0, 4'h0, 0);
            apply_stimulus(s, 1'b0, 32'h400, 32'h0, 4'h0, 1);
            apply_stimulus(s, 1'b1, 32'h404, 32'h5555_AAAA, 4'hF, 0);
            apply_stimulus(s, 1'b0, 32'h4, 32'h0, 4'h0, 0);
            apply_stimulus(s, 1'b1, 32'h8, 32'h1122_3344, 4'h0, 0);
            apply_stimulus(s, 1'b0, 32'h8, 32'h0, 4'h0, 0);
        end

        for (int i = 0; i < 60; i++) begin
            apply_stimulus($urandom_range(0, N - 1), 1'($urandom), rand_addr(),
                           $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        @(negedge clock);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'h1234_5678;
        req_wstrb[2] = 4'hF;
        begin
            int n;
            n = 0;
            while (req_ready[2] !== 1'b1 && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (n >= 20) check_output("abort_req_ready_timeout", 32'd0, 32'd1);
        end
        @(negedge clock);
        reset_n      = 1'b0;
        req_valid[2] = 1'b0;
        #1;
        for (int s = 0; s < N; s++) check_idle_reset(s);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        apply_stimulus(2, 1'b0, 32'h20, 32'h0, 4'h0, 0);
        apply_stimulus(2, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0);
        apply_stimulus(2, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
